// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the accumulator core: FETCH/DECODE/EXEC/HALT stage FSM,
// opcode decode into single-cycle commit strobes, memory-ready stalls and call-depth tracking.
module control_sequencer #(
  parameter int unsigned OPW   = 5,
  parameter int unsigned ALUW  = 5,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [OPW-1:0]  opcode,
  input  logic            equalQ,
  input  logic            gtQ,
  input  logic            ltQ,
  input  logic            zeroQ,
  input  logic            mem_ready,
  output logic            fetch_req,
  output logic [1:0]      stage,
  output logic            mem_req,
  output logic            memRead,
  output logic            memWrite,
  output logic            regWrite,
  output logic            memToReg,
  output logic            regToReg,
  output logic            regToMem,
  output logic            jump,
  output logic            call,
  output logic            ret,
  output logic            lea,
  output logic [ALUW-1:0] ALUOp,
  output logic [DW-1:0]   call_depth,
  output logic            fault,
  output logic            instr_done
);

  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StDecode = 2'b01,
    StExec   = 2'b10,
    StHalt   = 2'b11
  } state_e;

  localparam logic [OPW-1:0] OpTog   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OpMov   = OPW'(5'b00001);
  localparam logic [OPW-1:0] OpJe    = OPW'(5'b00011);
  localparam logic [OPW-1:0] OpJz    = OPW'(5'b00100);
  localparam logic [OPW-1:0] OpCmp   = OPW'(5'b00101);
  localparam logic [OPW-1:0] OpJmp   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OpLea   = OPW'(5'b01000);
  localparam logic [OPW-1:0] OpStore = OPW'(5'b01001);
  localparam logic [OPW-1:0] OpLoad  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OpCall  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OpRet   = OPW'(5'b01100);
  localparam logic [OPW-1:0] OpJlt   = OPW'(5'b11001);
  localparam logic [OPW-1:0] OpJgt   = OPW'(5'b11010);
  localparam logic [OPW-1:0] OpCmpu  = OPW'(5'b11011);
  localparam logic [OPW-1:0] OpNop   = OPW'(5'b11111);

  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  state_e          state_q, state_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [ALUW-1:0] alu_op_q, alu_op_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            fault_q, fault_d;
  logic            alu_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      opcode_q <= OpNop;
      alu_op_q <= '0;
      depth_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      alu_op_q <= alu_op_d;
      depth_q  <= depth_d;
      fault_q  <= fault_d;
    end
  end

  // Anything not claimed by a control-flow, move or memory opcode is passed to the ALU.
  always_comb begin
    case (opcode_q)
      OpTog, OpMov, OpJe, OpJz, OpJmp, OpLea, OpStore, OpLoad, OpCall, OpRet, OpJlt, OpJgt:
        alu_class = 1'b0;
      default: alu_class = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    alu_op_d   = alu_op_q;
    depth_d    = depth_q;
    fault_d    = fault_q;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    memToReg   = 1'b0;
    regToReg   = 1'b0;
    regToMem   = 1'b0;
    jump       = 1'b0;
    call       = 1'b0;
    ret        = 1'b0;
    lea        = 1'b0;
    instr_done = 1'b0;

    unique case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_op_d = alu_class ? ALUW'(opcode_q) : '0;
        state_d  = StExec;
      end
      StExec: begin
        case (opcode_q)
          OpLoad: begin
            mem_req = 1'b1;
            memRead = 1'b1;
            if (mem_ready) begin
              memToReg   = 1'b1;
              regWrite   = 1'b1;
              instr_done = 1'b1;
              state_d    = StFetch;
            end
          end
          OpStore: begin
            mem_req = 1'b1;
            if (mem_ready) begin
              memWrite   = 1'b1;
              regToMem   = 1'b1;
              instr_done = 1'b1;
              state_d    = StFetch;
            end
          end
          OpCall: begin
            if (depth_q < DepthMax) begin
              call       = 1'b1;
              jump       = 1'b1;
              depth_d    = depth_q + DW'(1);
              instr_done = 1'b1;
              state_d    = StFetch;
            end else begin
              fault_d = 1'b1;
              state_d = StHalt;
            end
          end
          OpRet: begin
            if (depth_q != '0) begin
              ret        = 1'b1;
              jump       = 1'b1;
              depth_d    = depth_q - DW'(1);
              instr_done = 1'b1;
              state_d    = StFetch;
            end else begin
              fault_d = 1'b1;
              state_d = StHalt;
            end
          end
          default: begin
            instr_done = 1'b1;
            state_d    = StFetch;
            case (opcode_q)
              OpTog, OpCmp, OpCmpu, OpNop: ;
              OpMov: begin
                regWrite = 1'b1;
                regToReg = 1'b1;
              end
              OpJmp: jump = 1'b1;
              OpJe:  jump = equalQ;
              OpJz:  jump = zeroQ;
              OpJlt: jump = ltQ;
              OpJgt: jump = gtQ;
              OpLea: begin
                lea      = 1'b1;
                regWrite = 1'b1;
              end
              default: regWrite = 1'b1;
            endcase
          end
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  assign stage      = state_q;
  assign ALUOp      = alu_op_q;
  assign call_depth = depth_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (DEPTH=2): stage sequencing, decode strobes, memory
// stalls, call/return nesting faults and asynchronous reset.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [4:0] opcode;
  logic       equalQ, gtQ, ltQ, zeroQ;
  logic       mem_ready;
  logic       fetch_req;
  logic [1:0] stage;
  logic       mem_req, memRead, memWrite, regWrite, memToReg, regToReg, regToMem;
  logic       jump, call, ret, lea;
  logic [4:0] ALUOp;
  logic [1:0] call_depth;
  logic       fault, instr_done;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.OPW(5), .ALUW(5), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .equalQ     (equalQ),
    .gtQ        (gtQ),
    .ltQ        (ltQ),
    .zeroQ      (zeroQ),
    .mem_ready  (mem_ready),
    .fetch_req  (fetch_req),
    .stage      (stage),
    .mem_req    (mem_req),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .memToReg   (memToReg),
    .regToReg   (regToReg),
    .regToMem   (regToMem),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .lea        (lea),
    .ALUOp      (ALUOp),
    .call_depth (call_depth),
    .fault      (fault),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an opcode in FETCH and advance to its first EXEC cycle.
  task automatic to_exec(input logic [4:0] op);
    opcode      = op;
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 5'b0; mem_ready = 1'b0;
    equalQ = 1'b0; gtQ = 1'b0; ltQ = 1'b0; zeroQ = 1'b0;
    cyc(); cyc();
    chk("rst_stage", stage, 2'b00);
    chk("rst_aluop", ALUOp, 5'd0);
    chk("rst_depth", call_depth, 2'd0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_done", instr_done, 1'b0);
    rst_n = 1'b1;

    // ALU op 10000
    chk("alu_fetch_req", fetch_req, 1'b1);
    opcode = 5'b10000; instr_valid = 1'b1;
    cyc();
    chk("alu_stage_dec", stage, 2'b01);
    chk("alu_regw_dec", regWrite, 1'b0);
    instr_valid = 1'b0;
    cyc();
    chk("alu_stage_exec", stage, 2'b10);
    chk("alu_aluop", ALUOp, 5'b10000);
    chk("alu_regw", regWrite, 1'b1);
    chk("alu_done", instr_done, 1'b1);
    cyc();
    chk("alu_stage_back", stage, 2'b00);
    chk("alu_regw_after", regWrite, 1'b0);
    chk("alu_done_after", instr_done, 1'b0);

    // Load with three stall cycles
    mem_ready = 1'b0;
    to_exec(5'b01010);
    chk("ld_aluop", ALUOp, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_memreq", mem_req, 1'b1);
      chk("ld_wait_memread", memRead, 1'b1);
      chk("ld_wait_regw", regWrite, 1'b0);
      chk("ld_wait_done", instr_done, 1'b0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_commit_stage", stage, 2'b10);
    chk("ld_commit_memreq", mem_req, 1'b1);
    chk("ld_commit_regw", regWrite, 1'b1);
    chk("ld_commit_m2r", memToReg, 1'b1);
    chk("ld_commit_done", instr_done, 1'b1);
    cyc();
    mem_ready = 1'b0;
    chk("ld_after_stage", stage, 2'b00);
    chk("ld_after_memreq", mem_req, 1'b0);
    chk("ld_after_m2r", memToReg, 1'b0);

    // Store with immediate ready
    mem_ready = 1'b1;
    to_exec(5'b01001);
    chk("st_memwrite", memWrite, 1'b1);
    chk("st_r2m", regToMem, 1'b1);
    chk("st_memread", memRead, 1'b0);
    chk("st_regw", regWrite, 1'b0);
    cyc();
    mem_ready = 1'b0;
    chk("st_after_memw", memWrite, 1'b0);

    // mov, lea
    to_exec(5'b00001);
    chk("mov_regw", regWrite, 1'b1);
    chk("mov_r2r", regToReg, 1'b1);
    cyc();
    to_exec(5'b01000);
    chk("lea_lea", lea, 1'b1);
    chk("lea_regw", regWrite, 1'b1);
    cyc();

    // Conditional jumps
    equalQ = 1'b0;
    to_exec(5'b00011);
    chk("je0_jump", jump, 1'b0);
    chk("je0_done", instr_done, 1'b1);
    cyc();
    equalQ = 1'b1;
    to_exec(5'b00011);
    chk("je1_jump", jump, 1'b1);
    cyc();
    chk("je1_jump_after", jump, 1'b0);
    equalQ = 1'b0; ltQ = 1'b1;
    to_exec(5'b11001);
    chk("jlt_jump", jump, 1'b1);
    cyc();
    ltQ = 1'b0; gtQ = 1'b1;
    to_exec(5'b00100);
    chk("jz0_jump", jump, 1'b0);
    cyc();
    gtQ = 1'b0;

    // CMP
    to_exec(5'b00101);
    chk("cmp_regw", regWrite, 1'b0);
    chk("cmp_aluop", ALUOp, 5'b00101);
    chk("cmp_done", instr_done, 1'b1);
    cyc();

    // Call overflow at DEPTH=2
    to_exec(5'b01011);
    chk("call1_call", call, 1'b1);
    chk("call1_jump", jump, 1'b1);
    cyc();
    chk("call1_depth", call_depth, 2'd1);
    to_exec(5'b01011);
    chk("call2_call", call, 1'b1);
    cyc();
    chk("call2_depth", call_depth, 2'd2);
    to_exec(5'b01011);
    chk("call3_call", call, 1'b0);
    chk("call3_jump", jump, 1'b0);
    cyc();
    chk("call3_stage", stage, 2'b11);
    chk("call3_fault", fault, 1'b1);
    chk("call3_depth", call_depth, 2'd2);
    chk("call3_fetch", fetch_req, 1'b0);
    instr_valid = 1'b1; opcode = 5'b10000;
    cyc(); cyc(); cyc();
    chk("halt_stage", stage, 2'b11);
    chk("halt_fault", fault, 1'b1);
    chk("halt_regw", regWrite, 1'b0);
    instr_valid = 1'b0;
    do_reset();
    chk("rst2_stage", stage, 2'b00);
    chk("rst2_fault", fault, 1'b0);
    chk("rst2_depth", call_depth, 2'd0);

    // Return underflow
    to_exec(5'b01100);
    chk("ret0_ret", ret, 1'b0);
    chk("ret0_jump", jump, 1'b0);
    cyc();
    chk("ret0_stage", stage, 2'b11);
    chk("ret0_fault", fault, 1'b1);
    chk("ret0_depth", call_depth, 2'd0);
    do_reset();
    to_exec(5'b01011);
    cyc();
    chk("rc_depth_a", call_depth, 2'd1);
    to_exec(5'b01100);
    chk("rc_ret", ret, 1'b1);
    chk("rc_jump", jump, 1'b1);
    cyc();
    chk("rc_depth_b", call_depth, 2'd0);
    to_exec(5'b01011);
    cyc();
    chk("rc_depth_c", call_depth, 2'd1);

    // Reset during a memory wait
    mem_ready = 1'b0;
    to_exec(5'b01010);
    cyc();
    chk("mr_wait_memreq", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_memreq", mem_req, 1'b0);
    chk("mr_memread", memRead, 1'b0);
    chk("mr_regw", regWrite, 1'b0);
    chk("mr_done", instr_done, 1'b0);
    chk("mr_stage", stage, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mr_after_stage", stage, 2'b00);
    chk("mr_after_depth", call_depth, 2'd0);
    chk("mr_after_memreq", mem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
